alert_handler_init_seq: RTL and testbench



---
 rtl/alert_pkg.sv | 28 ++
 rtl/alert_handler_init_seq_prim_count.sv | 43 ++++
 rtl/alert_handler_init_seq.sv | 133 +++++++++++++
 tb/tb_alert_handler_init_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alert_pkg.sv
// Shared alert handler definitions used by the per-channel init sequencer:
// multibit trigger encodings, sparse FSM state encoding and default timing.
package alert_pkg;

    // Four-bit multibit boolean carried on the init trigger.
    typedef logic [3:0] mubi4_t;

    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    // Default cycle budgets for the init handshake and post-ack settling.
    localparam int unsigned AlertInitTimeoutCycles = 256;
    localparam int unsigned AlertInitSettleCycles  = 4;

    // Sparse state encoding: every pair of legal states differs in at least
    // three bits, so a single upset lands on an illegal code.
    typedef enum logic [5:0] {
        StInit   = 6'b100110,
        StSettle = 6'b011011,
        StReady  = 6'b110001
    } alert_init_st_e;

    // Fail-safe decode: only the exact "false" code counts as inactive.
    function automatic logic mubi4IsActive(input mubi4_t val);
        return (val != MuBi4False);
    endfunction

endpackage

// File: rtl/alert_handler_init_seq_prim_count.sv
// prim_count: hardened saturating up-counter with clear and increment.
// The value is kept in two redundant registers; any disagreement between
// them is reported on o_err so the owner can fall back to a safe state.
module prim_count #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_clr,
    input  logic             i_incr,
    output logic [Width-1:0] o_count,
    output logic             o_err
);

    logic [Width-1:0] r_count;
    logic [Width-1:0] r_countDup;
    logic [Width-1:0] w_countNext;

    // Next value: clear wins over increment, increment stops at all-ones.
    always_comb begin
        w_countNext = r_count;
        if (i_clr) begin
            w_countNext = '0;
        end else if (i_incr && (r_count != '1)) begin
            w_countNext = r_count + 1'b1;
        end
    end

    // Both copies load the same next value; they only diverge on a fault.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_countDup <= '0;
        end else begin
            r_count    <= w_countNext;
            r_countDup <= w_countNext;
        end
    end

    assign o_count = r_count;
    assign o_err   = (r_count != r_countDup);

endmodule

// File: rtl/alert_handler_init_seq.sv
// alert_handler_init_seq: per-channel re-initialization sequencer.
// Holds the channel masked while its receiver is (re)initializing, then
// unmasks after a short settle period. Optional macro
// ALERT_HANDLER_INIT_TIMEOUT_EN enables timeout detection on init_fail_o.
module alert_handler_init_seq
    import alert_pkg::*;
#(
    parameter int unsigned TimeoutCycles = AlertInitTimeoutCycles,
    parameter int unsigned SettleCycles  = AlertInitSettleCycles,
    parameter int unsigned CntW          = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] init_trig_i,
    input  logic       init_ack_i,
    output logic       init_req_o,
    output logic       mask_o,
    output logic       init_fail_o
);

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles);

    alert_init_st_e  r_state;
    alert_init_st_e  w_nextState;
    logic            w_trigActive;
    logic            w_cntClr;
    logic            w_cntIncr;
    logic            w_cntErr;
    logic            w_failSet;
    logic [CntW-1:0] w_count;

    assign w_trigActive = mubi4IsActive(mubi4_t'(init_trig_i));

    prim_count #(
        .Width (CntW)
    ) u_prim_count (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_clr   (w_cntClr),
        .i_incr  (w_cntIncr),
        .o_count (w_count),
        .o_err   (w_cntErr)
    );

    // Next-state and counter control; trigger beats ack, ack beats timeout.
    always_comb begin
        w_nextState = r_state;
        w_cntClr    = 1'b0;
        w_cntIncr   = 1'b0;
        w_failSet   = 1'b0;
        unique case (r_state)
            StInit: begin
                if (w_trigActive) begin
                    w_cntClr = 1'b1;
                end else if (init_ack_i) begin
                    w_nextState = StSettle;
                    w_cntClr    = 1'b1;
                end else begin
`ifdef ALERT_HANDLER_INIT_TIMEOUT_EN
                    if (w_count >= TimeoutLast) begin
                        w_failSet = 1'b1;
                        w_cntClr  = 1'b1;
                    end else begin
                        w_cntIncr = 1'b1;
                    end
`else
                    w_cntClr = 1'b1;
`endif
                end
            end
            StSettle: begin
                if (w_trigActive) begin
                    w_nextState = StInit;
                    w_cntClr    = 1'b1;
                end else if (w_count >= SettleLast) begin
                    w_nextState = StReady;
                    w_cntClr    = 1'b1;
                end else begin
                    w_cntIncr = 1'b1;
                end
            end
            StReady: begin
                if (w_trigActive) begin
                    w_nextState = StInit;
                    w_cntClr    = 1'b1;
                end
            end
            default: begin
                w_nextState = StInit;
                w_cntClr    = 1'b1;
            end
        endcase
        if (w_cntErr) begin
            w_nextState = StInit;
            w_cntClr    = 1'b1;
            w_failSet   = 1'b0;
        end
    end

    // State register; reset restarts the handshake from StInit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StInit;
        end else begin
            r_state <= w_nextState;
        end
    end

`ifdef ALERT_HANDLER_INIT_TIMEOUT_EN
    logic r_fail;

    // Registered one-cycle timeout pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= w_failSet;
        end
    end

    assign init_fail_o = r_fail;
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (w_count == TimeoutLast) | w_failSet;
    assign init_fail_o     = 1'b0;
`endif

    // Moore outputs; illegal codes look like StInit (requesting and masked).
    assign init_req_o = (r_state != StSettle) && (r_state != StReady);
    assign mask_o     = (r_state != StReady);

endmodule

// File: tb/tb_alert_handler_init_seq.sv
// Directed testbench for alert_handler_init_seq with TimeoutCycles=16 and
// SettleCycles=4. Inputs change on the falling edge, outputs are checked on
// the falling edge after each rising edge.
module tb_alert_handler_init_seq;

    localparam logic [3:0] TrigTrue  = 4'h6;
    localparam logic [3:0] TrigFalse = 4'h9;

`ifdef ALERT_HANDLER_INIT_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] initTrig;
    logic       initAck;
    logic       initReq;
    logic       mask;
    logic       initFail;

    int errors = 0;
    int checks = 0;

    alert_handler_init_seq #(
        .TimeoutCycles (16),
        .SettleCycles  (4),
        .CntW          (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_trig_i (initTrig),
        .init_ack_i  (initAck),
        .init_req_o  (initReq),
        .mask_o      (mask),
        .init_fail_o (initFail)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, then advance one rising edge and land on the falling edge.
    task automatic applyStimulus(input logic [3:0] trig, input logic ack);
        initTrig = trig;
        initAck  = ack;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input logic req, input logic msk,
                            input logic fail);
        checkOutput({tag, ".req"}, 32'(initReq), 32'(req));
        checkOutput({tag, ".mask"}, 32'(mask), 32'(msk));
        checkOutput({tag, ".fail"}, 32'(initFail), 32'(fail));
    endtask

    initial begin
        rst      = 1'b1;
        initTrig = TrigTrue;
        initAck  = 1'b0;
        @(negedge clk);

        // Reset state.
        applyStimulus(TrigTrue, 1'b0);
        checkAll("reset", 1'b1, 1'b1, 1'b0);
        rst = 1'b0;

        // Trigger held active: stay initializing.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(TrigTrue, 1'b0);
            checkAll($sformatf("trigHold%0d", i), 1'b1, 1'b1, 1'b0);
        end

        // Trigger released, ack arrives on the fourth edge.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(TrigFalse, 1'b0);
            checkAll($sformatf("waitAck%0d", i), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(TrigFalse, 1'b1);
        checkAll("ackEdge", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(TrigFalse, 1'b0);
            checkAll($sformatf("settle%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(TrigFalse, 1'b0);
        checkAll("ready", 1'b0, 1'b0, 1'b0);

        // Ack is ignored in StReady.
        applyStimulus(TrigFalse, 1'b1);
        checkAll("readyAckIgnored", 1'b0, 1'b0, 1'b0);

        // Invalid trigger encoding counts as active.
        applyStimulus(4'b0000, 1'b0);
        checkAll("invalidTrig", 1'b1, 1'b1, 1'b0);

        // No ack: timeout pulses every 16 edges when enabled.
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(TrigFalse, 1'b0);
            checkAll($sformatf("timeout%0d", k), 1'b1, 1'b1,
                     TimeoutEn && ((k % 16) == 0));
        end

        // Ack on the same edge the counter sits at 15: ack wins.
        applyStimulus(TrigTrue, 1'b0);
        checkAll("rearm", 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(TrigFalse, 1'b0);
            checkAll($sformatf("preAck%0d", k), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(TrigFalse, 1'b1);
        checkAll("ackAtLimit", 1'b0, 1'b1, 1'b0);

        // Trigger during settle returns to StInit; settle restarts on next ack.
        applyStimulus(TrigFalse, 1'b0);
        checkAll("settleA1", 1'b0, 1'b1, 1'b0);
        applyStimulus(TrigFalse, 1'b0);
        checkAll("settleA2", 1'b0, 1'b1, 1'b0);
        applyStimulus(TrigTrue, 1'b0);
        checkAll("settleAbort", 1'b1, 1'b1, 1'b0);
        applyStimulus(TrigFalse, 1'b1);
        checkAll("reAck", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(TrigFalse, 1'b0);
            checkAll($sformatf("settleB%0d", i), 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(TrigFalse, 1'b0);
        checkAll("readyB", 1'b0, 1'b0, 1'b0);

        // One-cycle reset pulse in StReady.
        rst = 1'b1;
        applyStimulus(TrigFalse, 1'b0);
        checkAll("midReset", 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(TrigFalse, 1'b0);
        checkAll("postReset", 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
